// File: rtl/amo_sequencer.sv
// amo_sequencer
//   Control FSM that walks RV32A instructions (LR.W, SC.W, AMO*.W) through the
//   multicycle datapath's AMO resources. It also owns the single-hart load
//   reservation.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start from the main control unit
//   LD_REQ | load request outstanding (LR / AMO read)
//   LD_WB  | write load data to rd and temp; LR sets the reservation here
//   CALC   | ALU combines temp with rs2, result back into temp
//   ST_REQ | store request outstanding (AMO result or SC rs2)
//   SC_WB  | write SC success/fail flag to rd, drop the reservation
//   ERR    | misaligned or illegal op reported, no memory access
//
// Ports
//   clk, reset                  clock, async active-high reset
//   start, amo_op, addr         request from the main control unit
//   mem_valid/mem_we/mem_ready  memory handshake
//   snoop_we, snoop_addr        external writes, may kill the reservation
//   resv_clear                  trap / mret / context switch kills reservation
//   amo_* / select_* / srca_*   datapath strobes
//   reg_write, busy, done       sequencing status
//   misaligned, illegal         error flags, pulsed with done
module amo_sequencer #(
  parameter int RESV_GRANULE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  amo_op,
  input  logic [31:0] addr,
  output logic        mem_valid,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic        snoop_we,
  input  logic [31:0] snoop_addr,
  input  logic        resv_clear,
  output logic        amo_buffered_address,
  output logic        amo_temp_write_operation,
  output logic        select_ALUResult,
  output logic        select_amo_temp,
  output logic        srca_amo_temp,
  output logic [4:0]  amo_alu_op,
  output logic        muxed_Aluout_or_amo_rd_wr,
  output logic        amo_buffered_data,
  output logic        amo_set_reserved_state_load,
  output logic        amo_reserved_state_load,
  output logic        reg_write,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        illegal
);

  localparam int GW = 32 - RESV_GRANULE_LOG2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_WB, S_CALC, S_ST_REQ, S_SC_WB, S_ERR
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR,
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [GW-1:0]   gran_q, gran_d;
  logic            fail_q, fail_d;
  logic            mis_q, mis_d;
  logic            ill_q, ill_d;
  logic            resv_valid_q, resv_valid_d;
  logic [GW-1:0]   resv_gran_q, resv_gran_d;

  logic            lr_set;
  logic            sc_clr;
  logic            sc_match;
  logic            start_mis;
  logic            start_ill;
  logic [GW-1:0]   addr_gran;
  logic [GW-1:0]   snoop_gran;
  logic            unused_addr_bits;

  assign addr_gran  = addr[31:RESV_GRANULE_LOG2];
  assign snoop_gran = snoop_addr[31:RESV_GRANULE_LOG2];
  assign start_mis  = (addr[1:0] != 2'b00);
  assign start_ill  = !op_legal(amo_op);
  assign unused_addr_bits = ^{addr, snoop_addr};

  // A clear or matching snoop arriving alongside the SC start forces failure.
  assign sc_match = resv_valid_q && (addr_gran == resv_gran_q) && !resv_clear &&
                    !(snoop_we && (snoop_gran == resv_gran_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      gran_q       <= '0;
      fail_q       <= 1'b0;
      mis_q        <= 1'b0;
      ill_q        <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_gran_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      gran_q       <= gran_d;
      fail_q       <= fail_d;
      mis_q        <= mis_d;
      ill_q        <= ill_d;
      resv_valid_q <= resv_valid_d;
      resv_gran_q  <= resv_gran_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    gran_d  = gran_q;
    fail_d  = fail_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    lr_set  = 1'b0;
    sc_clr  = 1'b0;

    mem_valid                 = 1'b0;
    mem_we                    = 1'b0;
    amo_buffered_address      = 1'b0;
    amo_temp_write_operation  = 1'b0;
    select_ALUResult          = 1'b0;
    select_amo_temp           = 1'b0;
    srca_amo_temp             = 1'b0;
    muxed_Aluout_or_amo_rd_wr = 1'b0;
    amo_buffered_data         = 1'b0;
    reg_write                 = 1'b0;
    done                      = 1'b0;
    misaligned                = 1'b0;
    illegal                   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          amo_buffered_address = 1'b1;
          op_d   = amo_op;
          gran_d = addr_gran;
          mis_d  = start_mis;
          ill_d  = start_ill;
          fail_d = 1'b0;
          if (start_mis || start_ill) begin
            state_d = S_ERR;
          end else if (amo_op == OP_SC) begin
            if (sc_match) begin
              state_d = S_ST_REQ;
            end else begin
              fail_d  = 1'b1;
              state_d = S_SC_WB;
            end
          end else begin
            state_d = S_LD_REQ;
          end
        end
      end
      S_LD_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        reg_write                = 1'b1;
        amo_temp_write_operation = 1'b1;
        if (op_q == OP_LR) begin
          lr_set  = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        srca_amo_temp            = 1'b1;
        amo_temp_write_operation = 1'b1;
        select_ALUResult         = 1'b1;
        state_d                  = S_ST_REQ;
      end
      S_ST_REQ: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        if (op_q == OP_SC) begin
          if (mem_ready) begin
            fail_d  = 1'b0;
            state_d = S_SC_WB;
          end
        end else begin
          select_amo_temp = 1'b1;
          if (mem_ready) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_SC_WB: begin
        reg_write                 = 1'b1;
        muxed_Aluout_or_amo_rd_wr = 1'b1;
        amo_buffered_data         = fail_q;
        done                      = 1'b1;
        sc_clr                    = 1'b1;
        state_d                   = S_IDLE;
      end
      S_ERR: begin
        done       = 1'b1;
        misaligned = mis_q;
        illegal    = ill_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reservation update. Clears are applied after the LR set so they win; a
  // snoop during the LR set is compared against the address being reserved.
  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_gran_d  = resv_gran_q;
    if (lr_set) begin
      resv_valid_d = 1'b1;
      resv_gran_d  = gran_q;
    end
    if (resv_clear || sc_clr || (snoop_we && (snoop_gran == resv_gran_d))) begin
      resv_valid_d = 1'b0;
    end
    amo_set_reserved_state_load = (resv_valid_d != resv_valid_q) ||
                                  (resv_valid_d && (resv_gran_d != resv_gran_q));
  end

  assign amo_reserved_state_load = resv_valid_q;
  assign amo_alu_op              = op_q;
  assign busy                    = (state_q != S_IDLE);

endmodule

// File: tb/tb_amo_sequencer.sv
module tb_amo_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  amo_op = '0;
  logic [31:0] addr = '0;
  logic        mem_valid, mem_we;
  logic        mem_ready = 1'b0;
  logic        snoop_we = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        resv_clear = 1'b0;
  logic        amo_buffered_address, amo_temp_write_operation, select_ALUResult;
  logic        select_amo_temp, srca_amo_temp;
  logic [4:0]  amo_alu_op;
  logic        muxed_Aluout_or_amo_rd_wr, amo_buffered_data;
  logic        amo_set_reserved_state_load, amo_reserved_state_load;
  logic        reg_write, busy, done, misaligned, illegal;

  amo_sequencer #(.RESV_GRANULE_LOG2(2)) dut (
    .clk(clk), .reset(reset), .start(start), .amo_op(amo_op), .addr(addr),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_ready(mem_ready),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr), .resv_clear(resv_clear),
    .amo_buffered_address(amo_buffered_address),
    .amo_temp_write_operation(amo_temp_write_operation),
    .select_ALUResult(select_ALUResult), .select_amo_temp(select_amo_temp),
    .srca_amo_temp(srca_amo_temp), .amo_alu_op(amo_alu_op),
    .muxed_Aluout_or_amo_rd_wr(muxed_Aluout_or_amo_rd_wr),
    .amo_buffered_data(amo_buffered_data),
    .amo_set_reserved_state_load(amo_set_reserved_state_load),
    .amo_reserved_state_load(amo_reserved_state_load),
    .reg_write(reg_write), .busy(busy), .done(done),
    .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010;
  localparam logic [4:0] F_SC = 5'b00011, F_XOR = 5'b00100, F_BAD = 5'b11111;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wait_n  = 0;
  int req_cnt = 0;
  int ld_cnt = 0, st_cnt = 0, rw_cnt = 0;
  logic pend = 1'b0, pend_we = 1'b0;

  typedef struct {
    string name;
    int    cyc;
    logic  bd;
    logic  mis;
    logic  ill;
    int    ld;
    int    st;
    int    rw;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc++;

  // Memory responder: completes each request after wait_n wait cycles.
  always @(negedge clk) begin
    if (mem_valid) begin
      mem_ready = (req_cnt == wait_n);
      req_cnt   = mem_ready ? 0 : req_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      req_cnt   = 0;
    end
  end

  // Scoreboard: accumulate activity per transaction, compare on done.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (pend) begin
        n_tests++;
        if (mem_valid !== 1'b1 || mem_we !== pend_we) begin
          n_fail++;
          $display("FAIL mem_stable: valid=%b we=%b, required valid=1 we=%b", mem_valid, mem_we, pend_we);
        end
      end
      pend    = mem_valid && !mem_ready;
      pend_we = mem_we;
      if (mem_valid && mem_ready) begin
        if (mem_we) st_cnt++; else ld_cnt++;
      end
      if (reg_write) rw_cnt++;
      if (done) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc !== e.cyc || amo_buffered_data !== e.bd || misaligned !== e.mis ||
              illegal !== e.ill || ld_cnt !== e.ld || st_cnt !== e.st || rw_cnt !== e.rw) begin
            n_fail++;
            $display("FAIL %s: cyc=%0d bd=%b mis=%b ill=%b ld=%0d st=%0d rw=%0d, required cyc=%0d bd=%b mis=%b ill=%b ld=%0d st=%0d rw=%0d",
                     e.name, cyc, amo_buffered_data, misaligned, illegal, ld_cnt, st_cnt, rw_cnt,
                     e.cyc, e.bd, e.mis, e.ill, e.ld, e.st, e.rw);
          end
        end
        ld_cnt = 0; st_cnt = 0; rw_cnt = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input int lat, input logic bd, input logic mis, input logic ill,
                       input int ld, input int st, input int rw);
    exp_t e;
    @(negedge clk);
    amo_op = op; addr = a; start = 1'b1;
    e.name = nm; e.cyc = cyc + lat; e.bd = bd; e.mis = mis; e.ill = ill;
    e.ld = ld; e.st = st; e.rw = rw;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (!busy && exp_q.size() == 0) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s_timeout: busy=%b pending=%0d, required idle", nm, busy, exp_q.size());
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({mem_valid, mem_we, done, busy, reg_write, amo_reserved_state_load,
         amo_set_reserved_state_load, amo_temp_write_operation, amo_alu_op} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: mv=%b we=%b done=%b busy=%b rw=%b resv=%b op=%b, required all 0",
               mem_valid, mem_we, done, busy, reg_write, amo_reserved_state_load, amo_alu_op);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lr_sc();
    exp_t e;
    wait_n = 0;
    @(negedge clk);
    amo_op = F_LR; addr = 32'h100; start = 1'b1;
    e.name = "lr_0x100"; e.cyc = cyc + 2; e.bd = 0; e.mis = 0; e.ill = 0;
    e.ld = 1; e.st = 0; e.rw = 1;
    exp_q.push_back(e);
    #1;
    n_tests++;
    if (amo_buffered_address !== 1'b1) begin
      n_fail++;
      $display("FAIL buffered_address: got %b, required 1", amo_buffered_address);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("lr_0x100");
    n_tests++;
    if (amo_reserved_state_load !== 1'b1) begin
      n_fail++;
      $display("FAIL lr_resv_set: got %b, required 1", amo_reserved_state_load);
    end
    issue("sc_ok_0x100", F_SC, 32'h100, 2, 1'b0, 1'b0, 1'b0, 0, 1, 1);
    wait_idle("sc_ok_0x100");
    n_tests++;
    if (amo_reserved_state_load !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_resv_cleared: got %b, required 0", amo_reserved_state_load);
    end
  endtask

  task automatic test_snoop();
    wait_n = 0;
    issue("lr_snoop", F_LR, 32'h100, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    wait_idle("lr_snoop");
    @(negedge clk);
    snoop_we = 1'b1; snoop_addr = 32'h104;
    #1;
    n_tests++;
    if (amo_set_reserved_state_load !== 1'b0) begin
      n_fail++;
      $display("FAIL snoop_other_granule_strobe: got %b, required 0", amo_set_reserved_state_load);
    end
    @(negedge clk);
    snoop_addr = 32'h102;
    #1;
    n_tests++;
    if (amo_set_reserved_state_load !== 1'b1 || amo_reserved_state_load !== 1'b1) begin
      n_fail++;
      $display("FAIL snoop_hit_strobe: strobe=%b resv=%b, required strobe=1 resv=1",
               amo_set_reserved_state_load, amo_reserved_state_load);
    end
    @(negedge clk);
    snoop_we = 1'b0;
    n_tests++;
    if (amo_reserved_state_load !== 1'b0) begin
      n_fail++;
      $display("FAIL snoop_resv_cleared: got %b, required 0", amo_reserved_state_load);
    end
    issue("sc_after_snoop", F_SC, 32'h100, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    wait_idle("sc_after_snoop");
  endtask

  task automatic test_amo_wait();
    wait_n = 0;
    issue("lr_0x700", F_LR, 32'h700, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    wait_idle("lr_0x700");
    wait_n = 3;
    issue("amoadd_wait3", F_ADD, 32'h200, 10, 1'b0, 1'b0, 1'b0, 1, 1, 1);
    #2;
    n_tests++;
    if (amo_alu_op !== F_ADD || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL amo_alu_op: op=%b busy=%b, required op=00000 busy=1", amo_alu_op, busy);
    end
    wait_idle("amoadd_wait3");
    n_tests++;
    if (amo_reserved_state_load !== 1'b1) begin
      n_fail++;
      $display("FAIL amo_keeps_resv: got %b, required 1", amo_reserved_state_load);
    end
  endtask

  task automatic test_lr_clear();
    wait_n = 0;
    issue("lr_0x300", F_LR, 32'h300, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    @(negedge clk);
    resv_clear = 1'b1;
    @(negedge clk);
    resv_clear = 1'b0;
    wait_idle("lr_0x300");
    n_tests++;
    if (amo_reserved_state_load !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins_over_lr: got %b, required 0", amo_reserved_state_load);
    end
    issue("sc_after_clear", F_SC, 32'h300, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    wait_idle("sc_after_clear");
  endtask

  task automatic test_errors();
    wait_n = 0;
    issue("lr_0x400", F_LR, 32'h400, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    wait_idle("lr_0x400");
    issue("swap_misaligned", F_SWAP, 32'h103, 1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    wait_idle("swap_misaligned");
    issue("funct5_illegal", F_BAD, 32'h100, 1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    wait_idle("funct5_illegal");
    n_tests++;
    if (amo_reserved_state_load !== 1'b1) begin
      n_fail++;
      $display("FAIL err_keeps_resv: got %b, required 1", amo_reserved_state_load);
    end
  endtask

  task automatic test_back_to_back();
    wait_n = 2;
    issue("amoxor_wait2", F_XOR, 32'h800, 8, 1'b0, 1'b0, 1'b0, 1, 1, 1);
    @(negedge clk);
    amo_op = F_LR; addr = 32'h900; start = 1'b1;
    #1;
    n_tests++;
    if (amo_buffered_address !== 1'b0 || amo_alu_op !== F_XOR) begin
      n_fail++;
      $display("FAIL start_while_busy: baddr=%b op=%b, required baddr=0 op=00100",
               amo_buffered_address, amo_alu_op);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("amoxor_wait2");
    wait_n = 0;
    issue("lr_0x500", F_LR, 32'h500, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    wait_idle("lr_0x500");
    issue("sc_other_granule", F_SC, 32'h504, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    wait_idle("sc_other_granule");
    n_tests++;
    if (amo_reserved_state_load !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_fail_clears_resv: got %b, required 0", amo_reserved_state_load);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    wait_n = 0;
    issue("lr_0x600", F_LR, 32'h600, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    wait_idle("lr_0x600");
    wait_n = 6;
    issue("amoadd_aborted", F_ADD, 32'h200, 16, 1'b0, 1'b0, 1'b0, 1, 1, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (mem_valid && mem_we) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_st_req: mem_we never seen, required store request");
    end
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || amo_reserved_state_load !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: mv=%b busy=%b resv=%b done=%b, required all 0",
               mem_valid, busy, amo_reserved_state_load, done);
    end
    exp_q.delete();
    ld_cnt = 0; st_cnt = 0; rw_cnt = 0; pend = 1'b0;
    wait_n = 0;
    @(negedge clk);
    reset = 1'b0;
    issue("lr_after_reset", F_LR, 32'h100, 2, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    wait_idle("lr_after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lr_sc();
    test_snoop();
    test_amo_wait();
    test_lr_clear();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
